// File: rtl/fdma_mc_frame_ctrl_if.sv
// Bus bundle for fdma_mc_frame_ctrl: per-channel write FIFO status and
// control, read FIFO status and control, and the FDMA packet port pair.
// The controller attaches through 'master'. The FIFO/FDMA side attaches through 'slave'.
interface fdma_mc_frame_ctrl_if #(
  parameter int WCH = 2
);
  logic [WCH-1:0]    w_fs;
  logic [WCH*12-1:0] w_fifo_cnt;
  logic [WCH-1:0]    w_fifo_rst;
  logic              r_fs;
  logic [2:0]        r_ch_sel;
  logic [11:0]       r_fifo_cnt;
  logic              r_fifo_rst;
  logic              pkg_wr_areq;
  logic              pkg_wr_last;
  logic [31:0]       pkg_wr_addr;
  logic [31:0]       pkg_wr_size;
  logic [2:0]        pkg_wr_ch;
  logic              pkg_rd_areq;
  logic              pkg_rd_last;
  logic [31:0]       pkg_rd_addr;
  logic [31:0]       pkg_rd_size;
  logic [WCH-1:0]    w_frame_done;
  logic [WCH-1:0]    w_abort;

  modport master (
    input  w_fs, w_fifo_cnt, r_fs, r_ch_sel, r_fifo_cnt, pkg_wr_last, pkg_rd_last,
    output w_fifo_rst, r_fifo_rst, pkg_wr_areq, pkg_wr_addr, pkg_wr_size, pkg_wr_ch,
           pkg_rd_areq, pkg_rd_addr, pkg_rd_size, w_frame_done, w_abort
  );

  modport slave (
    output w_fs, w_fifo_cnt, r_fs, r_ch_sel, r_fifo_cnt, pkg_wr_last, pkg_rd_last,
    input  w_fifo_rst, r_fifo_rst, pkg_wr_areq, pkg_wr_addr, pkg_wr_size, pkg_wr_ch,
           pkg_rd_areq, pkg_rd_addr, pkg_rd_size, w_frame_done, w_abort
  );
endinterface

// File: rtl/fdma_mc_frame_ctrl.sv
// fdma_mc_frame_ctrl: schedules WCH write streams and one selectable read
// stream onto a single FDMA packet port pair. Each channel rotates through
// BUF_NUM frame buffers. The reader always fetches the last completed buffer
// of the selected channel, so it never shows a half-written frame.
module fdma_mc_frame_ctrl #(
  parameter int          WCH         = 2,
  parameter int          BUF_NUM     = 3,
  parameter int          PKG_SIZE    = 256,
  parameter int          BEAT_BYTES  = 16,
  parameter int          FRAME_BYTES = 1228800,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] CH_STRIDE   = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE  = 32'h0040_0000,
  parameter int          RFIFO_DEPTH = 1024,
  parameter int          RST_CYC     = 10
) (
  input logic                  ui_clk,
  input logic                  ui_rstn,
  fdma_mc_frame_ctrl_if.master bus
);
  localparam int BURST_BYTES = PKG_SIZE * BEAT_BYTES;
  localparam int BURSTS      = FRAME_BYTES / BURST_BYTES;
  localparam int CH_W        = (WCH > 1) ? $clog2(WCH) : 1;
  localparam int BUF_W       = $clog2(BUF_NUM);
  localparam int BCNT_W      = $clog2(BURSTS + 1);
  localparam int RCNT_W      = $clog2(2 * RST_CYC);

  if ((FRAME_BYTES % BURST_BYTES) != 0 || BURSTS == 0) begin : g_frame_bytes_check
    $error("FRAME_BYTES must be a non-zero multiple of PKG_SIZE*BEAT_BYTES");
  end

  typedef enum logic [1:0] {CH_IDLE, CH_RST, CH_ARM} ch_st_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_st_e;
  typedef enum logic [1:0] {R_IDLE, R_RST, R_DATA_REQ, R_DATA_WAIT} rd_st_e;

  // Write-side state
  ch_st_e            ch_st_q      [WCH];
  ch_st_e            ch_st_d      [WCH];
  logic [RCNT_W-1:0] rcnt_q       [WCH];
  logic [RCNT_W-1:0] rcnt_d       [WCH];
  logic [BCNT_W-1:0] bcnt_q       [WCH];
  logic [BCNT_W-1:0] bcnt_d       [WCH];
  logic [BUF_W-1:0]  wbuf_q       [WCH];
  logic [BUF_W-1:0]  wbuf_d       [WCH];
  logic [BUF_W-1:0]  done_buf_q   [WCH];
  logic [BUF_W-1:0]  done_buf_d   [WCH];
  logic [WCH-1:0]    done_valid_q, done_valid_d;
  logic [WCH-1:0]    pend_q,       pend_d;
  logic [WCH-1:0]    w_fifo_rst_q, w_fifo_rst_d;
  logic [WCH-1:0]    w_frame_done_q, w_frame_done_d;
  logic [WCH-1:0]    w_abort_q,    w_abort_d;
  wr_st_e            wst_q,        wst_d;
  logic [CH_W-1:0]   wr_ch_q,      wr_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]       wr_addr_q,    wr_addr_d;

  // Read-side state
  rd_st_e            rd_st_q,      rd_st_d;
  logic [CH_W-1:0]   rch_q,        rch_d;
  logic [BUF_W-1:0]  rbuf_q,       rbuf_d;
  logic [BCNT_W-1:0] rd_bcnt_q,    rd_bcnt_d;
  logic [RCNT_W-1:0] rd_rcnt_q,    rd_rcnt_d;
  logic              rd_pend_q,    rd_pend_d;
  logic              r_fifo_rst_q, r_fifo_rst_d;
  logic              rd_areq_q,    rd_areq_d;
  logic [31:0]       rd_addr_q,    rd_addr_d;

  function automatic logic [31:0] buf_addr(input logic [CH_W-1:0]   ch,
                                           input logic [BUF_W-1:0]  b,
                                           input logic [BCNT_W-1:0] n);
    return BASE_ADDR + 32'(ch) * CH_STRIDE + 32'(b) * BUF_STRIDE
         + 32'(n) * 32'(BURST_BYTES);
  endfunction

  // Channel reset sequencing, round-robin write arbitration, burst completion and frame restarts
  always_comb begin
    int              idx;
    logic            grant_ok;
    logic [CH_W-1:0] grant_ch;
    logic [WCH-1:0]  elig;
    logic            in_flight;
    wst_d          = wst_q;
    wr_ch_d        = wr_ch_q;
    wr_addr_d      = wr_addr_q;
    last_grant_d   = last_grant_q;
    w_fifo_rst_d   = w_fifo_rst_q;
    w_frame_done_d = '0;
    w_abort_d      = w_abort_q;
    pend_d         = pend_q;
    ch_st_d        = ch_st_q;
    rcnt_d         = rcnt_q;
    bcnt_d         = bcnt_q;
    wbuf_d         = wbuf_q;
    done_buf_d     = done_buf_q;
    done_valid_d   = done_valid_q;
    idx            = 0;
    grant_ok       = 1'b0;
    grant_ch       = '0;
    elig           = '0;
    // A burst whose last beat arrives this cycle no longer counts as in flight.
    in_flight      = (wst_q == W_REQ) || (wst_q == W_WAIT && !bus.pkg_wr_last);

    for (int c = 0; c < WCH; c++) begin
      elig[c] = (ch_st_q[c] == CH_ARM) && !pend_q[c] && !bus.w_fs[c] &&
                (int'(bus.w_fifo_cnt[c*12 +: 12]) >= PKG_SIZE);
      if (ch_st_q[c] == CH_RST) begin
        rcnt_d[c]       = rcnt_q[c] + 1'b1;
        w_fifo_rst_d[c] = (int'(rcnt_q[c]) + 1 < RST_CYC);
        if (int'(rcnt_q[c]) == 2 * RST_CYC - 1) begin
          ch_st_d[c] = CH_ARM;
          bcnt_d[c]  = '0;
        end
      end
    end

    case (wst_q)
      W_IDLE: begin
        for (int i = 1; i <= WCH; i++) begin
          idx = int'(last_grant_q) + i;
          if (idx >= WCH) idx = idx - WCH;
          if (!grant_ok && elig[idx]) begin
            grant_ok = 1'b1;
            grant_ch = CH_W'(idx);
          end
        end
        if (grant_ok) begin
          wst_d        = W_REQ;
          wr_ch_d      = grant_ch;
          last_grant_d = grant_ch;
          wr_addr_d    = buf_addr(grant_ch, wbuf_q[grant_ch], bcnt_q[grant_ch]);
        end
      end
      W_REQ: wst_d = W_WAIT;
      W_WAIT: begin
        if (bus.pkg_wr_last) begin
          wst_d = W_IDLE;
          if (pend_q[wr_ch_q]) begin
            // Frame was restarted while this burst was out: restart wins, nothing is published.
            pend_d[wr_ch_q]       = 1'b0;
            ch_st_d[wr_ch_q]      = CH_RST;
            rcnt_d[wr_ch_q]       = '0;
            bcnt_d[wr_ch_q]       = '0;
            w_fifo_rst_d[wr_ch_q] = 1'b1;
          end else if (int'(bcnt_q[wr_ch_q]) + 1 == BURSTS) begin
            done_buf_d[wr_ch_q]     = wbuf_q[wr_ch_q];
            done_valid_d[wr_ch_q]   = 1'b1;
            wbuf_d[wr_ch_q]         = (int'(wbuf_q[wr_ch_q]) == BUF_NUM - 1) ? '0
                                                                             : wbuf_q[wr_ch_q] + 1'b1;
            w_frame_done_d[wr_ch_q] = 1'b1;
            bcnt_d[wr_ch_q]         = '0;
            ch_st_d[wr_ch_q]        = CH_IDLE;
          end else begin
            bcnt_d[wr_ch_q] = bcnt_q[wr_ch_q] + 1'b1;
          end
        end
      end
      default: wst_d = W_IDLE;
    endcase

    for (int c = 0; c < WCH; c++) begin
      if (bus.w_fs[c]) begin
        if (ch_st_q[c] != CH_IDLE) w_abort_d[c] = 1'b1;
        if (in_flight && int'(wr_ch_q) == c) begin
          pend_d[c] = 1'b1;
        end else begin
          ch_st_d[c]      = CH_RST;
          rcnt_d[c]       = '0;
          bcnt_d[c]       = '0;
          w_fifo_rst_d[c] = 1'b1;
        end
      end
    end
  end

  // Write-side registers
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      wst_q          <= W_IDLE;
      wr_ch_q        <= '0;
      last_grant_q   <= CH_W'(WCH - 1);
      wr_addr_q      <= '0;
      w_fifo_rst_q   <= '1;
      w_frame_done_q <= '0;
      w_abort_q      <= '0;
      pend_q         <= '0;
      done_valid_q   <= '0;
      for (int c = 0; c < WCH; c++) begin
        ch_st_q[c]    <= CH_IDLE;
        rcnt_q[c]     <= '0;
        bcnt_q[c]     <= '0;
        wbuf_q[c]     <= '0;
        done_buf_q[c] <= '0;
      end
    end else begin
      wst_q          <= wst_d;
      wr_ch_q        <= wr_ch_d;
      last_grant_q   <= last_grant_d;
      wr_addr_q      <= wr_addr_d;
      w_fifo_rst_q   <= w_fifo_rst_d;
      w_frame_done_q <= w_frame_done_d;
      w_abort_q      <= w_abort_d;
      pend_q         <= pend_d;
      done_valid_q   <= done_valid_d;
      ch_st_q        <= ch_st_d;
      rcnt_q         <= rcnt_d;
      bcnt_q         <= bcnt_d;
      wbuf_q         <= wbuf_d;
      done_buf_q     <= done_buf_d;
    end
  end

  // Read sequencing: latch channel/buffer on r_fs (seeing this cycle's write completion), reset FIFO, fetch BURSTS bursts
  always_comb begin
    logic [CH_W-1:0] sel;
    rd_st_d      = rd_st_q;
    rch_d        = rch_q;
    rbuf_d       = rbuf_q;
    rd_bcnt_d    = rd_bcnt_q;
    rd_rcnt_d    = rd_rcnt_q;
    rd_pend_d    = rd_pend_q;
    r_fifo_rst_d = r_fifo_rst_q;
    rd_areq_d    = 1'b0;
    rd_addr_d    = rd_addr_q;
    sel          = (int'(bus.r_ch_sel) >= WCH) ? '0 : bus.r_ch_sel[CH_W-1:0];

    case (rd_st_q)
      R_RST: begin
        rd_rcnt_d    = rd_rcnt_q + 1'b1;
        r_fifo_rst_d = (int'(rd_rcnt_q) + 1 < RST_CYC);
        if (int'(rd_rcnt_q) == 2 * RST_CYC - 1) begin
          rd_st_d   = R_DATA_REQ;
          rd_bcnt_d = '0;
        end
      end
      R_DATA_REQ: begin
        if (int'(bus.r_fifo_cnt) <= RFIFO_DEPTH - PKG_SIZE) begin
          rd_areq_d = 1'b1;
          rd_addr_d = buf_addr(rch_q, rbuf_q, rd_bcnt_q);
          rd_st_d   = R_DATA_WAIT;
        end
      end
      R_DATA_WAIT: begin
        if (bus.pkg_rd_last) begin
          if (rd_pend_q) begin
            rd_pend_d    = 1'b0;
            rd_st_d      = R_RST;
            rd_rcnt_d    = '0;
            rd_bcnt_d    = '0;
            r_fifo_rst_d = 1'b1;
          end else if (int'(rd_bcnt_q) + 1 == BURSTS) begin
            rd_st_d   = R_IDLE;
            rd_bcnt_d = '0;
          end else begin
            rd_bcnt_d = rd_bcnt_q + 1'b1;
            rd_st_d   = R_DATA_REQ;
          end
        end
      end
      default: ;
    endcase

    if (bus.r_fs) begin
      rch_d  = sel;
      rbuf_d = done_valid_d[sel] ? done_buf_d[sel] : '0;
      if (rd_st_q == R_DATA_WAIT && !bus.pkg_rd_last) begin
        rd_pend_d = 1'b1;
      end else begin
        rd_st_d      = R_RST;
        rd_rcnt_d    = '0;
        rd_bcnt_d    = '0;
        rd_pend_d    = 1'b0;
        rd_areq_d    = 1'b0;
        r_fifo_rst_d = 1'b1;
      end
    end
  end

  // Read-side registers
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      rd_st_q      <= R_IDLE;
      rch_q        <= '0;
      rbuf_q       <= '0;
      rd_bcnt_q    <= '0;
      rd_rcnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      r_fifo_rst_q <= 1'b1;
      rd_areq_q    <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      rd_st_q      <= rd_st_d;
      rch_q        <= rch_d;
      rbuf_q       <= rbuf_d;
      rd_bcnt_q    <= rd_bcnt_d;
      rd_rcnt_q    <= rd_rcnt_d;
      rd_pend_q    <= rd_pend_d;
      r_fifo_rst_q <= r_fifo_rst_d;
      rd_areq_q    <= rd_areq_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  assign bus.w_fifo_rst   = w_fifo_rst_q;
  assign bus.r_fifo_rst   = r_fifo_rst_q;
  assign bus.pkg_wr_areq  = (wst_q == W_REQ);
  assign bus.pkg_wr_addr  = wr_addr_q;
  assign bus.pkg_wr_size  = 32'(PKG_SIZE);
  assign bus.pkg_wr_ch    = 3'(wr_ch_q);
  assign bus.pkg_rd_areq  = rd_areq_q;
  assign bus.pkg_rd_addr  = rd_addr_q;
  assign bus.pkg_rd_size  = 32'(PKG_SIZE);
  assign bus.w_frame_done = w_frame_done_q;
  assign bus.w_abort      = w_abort_q;
endmodule

// File: tb/tb_fdma_mc_frame_ctrl.sv
// Directed bench for fdma_mc_frame_ctrl with 16 KiB frames (4 bursts of 4 KiB).
module tb_fdma_mc_frame_ctrl;
  logic ui_clk = 1'b0;
  logic ui_rstn;
  int   n_chk = 0;
  int   n_err = 0;

  fdma_mc_frame_ctrl_if #(.WCH(2)) bus ();

  fdma_mc_frame_ctrl #(
    .WCH(2), .BUF_NUM(3), .PKG_SIZE(256), .BEAT_BYTES(16), .FRAME_BYTES(16384),
    .BASE_ADDR(32'h0), .CH_STRIDE(32'h0100_0000), .BUF_STRIDE(32'h0040_0000),
    .RFIFO_DEPTH(1024), .RST_CYC(10)
  ) dut (
    .ui_clk (ui_clk),
    .ui_rstn(ui_rstn),
    .bus    (bus)
  );

  always #5 ui_clk = ~ui_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Wait for a write request, check it, hold it for 20 cycles, return last.
  task automatic wr_burst(input string tag, input logic [31:0] exp_addr, input logic [2:0] exp_ch,
                          input logic [1:0] fs_mask, input logic [1:0] exp_done);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge ui_clk);
      if (bus.pkg_wr_areq) got = 1'b1;
    end
    if (!got) begin
      chk({tag, " areq seen"}, 64'(got), 64'(1));
      return;
    end
    chk({tag, " addr"}, 64'(bus.pkg_wr_addr), 64'(exp_addr));
    chk({tag, " ch"}, 64'(bus.pkg_wr_ch), 64'(exp_ch));
    for (int k = 1; k < 20; k++) begin
      @(negedge ui_clk);
      if (k == 1) chk({tag, " areq one cycle"}, 64'(bus.pkg_wr_areq), 64'(0));
      bus.w_fs = (k == 10) ? fs_mask : 2'b00;
    end
    chk({tag, " addr hold"}, 64'(bus.pkg_wr_addr), 64'(exp_addr));
    chk({tag, " ch hold"}, 64'(bus.pkg_wr_ch), 64'(exp_ch));
    bus.pkg_wr_last = 1'b1;
    @(negedge ui_clk);
    bus.pkg_wr_last = 1'b0;
    chk({tag, " frame_done"}, 64'(bus.w_frame_done), 64'(exp_done));
  endtask

  task automatic rd_burst(input string tag, input logic [31:0] exp_addr);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge ui_clk);
      if (bus.pkg_rd_areq) got = 1'b1;
    end
    if (!got) begin
      chk({tag, " rd areq seen"}, 64'(got), 64'(1));
      return;
    end
    chk({tag, " rd addr"}, 64'(bus.pkg_rd_addr), 64'(exp_addr));
    repeat (19) @(negedge ui_clk);
    bus.pkg_rd_last = 1'b1;
    @(negedge ui_clk);
    bus.pkg_rd_last = 1'b0;
  endtask

  task automatic fs0_pulse();
    @(negedge ui_clk);
    bus.w_fs = 2'b01;
    @(negedge ui_clk);
    bus.w_fs = 2'b00;
  endtask

  task automatic r_fs_pulse(input logic [2:0] sel);
    @(negedge ui_clk);
    bus.r_ch_sel = sel;
    bus.r_fs     = 1'b1;
    @(negedge ui_clk);
    bus.r_fs     = 1'b0;
  endtask

  task automatic wr_frame0(input string tag, input logic [31:0] base);
    fs0_pulse();
    for (int b = 0; b < 4; b++)
      wr_burst($sformatf("%s b%0d", tag, b), base + 32'(b) * 32'h1000, 3'd0, 2'b00,
               (b == 3) ? 2'b01 : 2'b00);
  endtask

  initial begin
    logic [19:0] pat;
    int          rd_seen;
    bit          got;
    ui_rstn         = 1'b0;
    bus.w_fs        = '0;
    bus.w_fifo_cnt  = {12'd0, 12'd256};
    bus.r_fs        = 1'b0;
    bus.r_ch_sel    = 3'd0;
    bus.r_fifo_cnt  = 12'd0;
    bus.pkg_wr_last = 1'b0;
    bus.pkg_rd_last = 1'b0;
    repeat (3) @(negedge ui_clk);

    chk("rst w_fifo_rst", 64'(bus.w_fifo_rst), 64'(2'b11));
    chk("rst r_fifo_rst", 64'(bus.r_fifo_rst), 64'(1));
    chk("rst wr_areq", 64'(bus.pkg_wr_areq), 64'(0));
    chk("rst rd_areq", 64'(bus.pkg_rd_areq), 64'(0));
    chk("rst wr_addr", 64'(bus.pkg_wr_addr), 64'(0));
    chk("rst rd_addr", 64'(bus.pkg_rd_addr), 64'(0));
    chk("rst wr_ch", 64'(bus.pkg_wr_ch), 64'(0));
    chk("rst frame_done", 64'(bus.w_frame_done), 64'(0));
    chk("rst abort", 64'(bus.w_abort), 64'(0));
    chk("wr_size", 64'(bus.pkg_wr_size), 64'(256));
    chk("rd_size", 64'(bus.pkg_rd_size), 64'(256));

    ui_rstn = 1'b1;
    @(negedge ui_clk);
    bus.w_fs = 2'b01;
    pat = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ui_clk);
      bus.w_fs = 2'b00;
      pat[i]   = bus.w_fifo_rst[0];
    end
    chk("w_fifo_rst0 10 high 10 low", 64'(pat), 64'(20'h003FF));
    chk("w_fifo_rst1 untouched", 64'(bus.w_fifo_rst[1]), 64'(1));

    for (int b = 0; b < 4; b++)
      wr_burst($sformatf("frmA b%0d", b), 32'(b) * 32'h1000, 3'd0, 2'b00,
               (b == 3) ? 2'b01 : 2'b00);
    @(negedge ui_clk);
    chk("frame_done one cycle", 64'(bus.w_frame_done), 64'(0));
    chk("no abort after frmA", 64'(bus.w_abort), 64'(0));

    wr_frame0("frmB", 32'h0040_0000);

    // Read the completed buffer 1 of ch0.
    r_fs_pulse(3'd0);
    for (int b = 0; b < 4; b++)
      rd_burst($sformatf("rdA b%0d", b), 32'h0040_0000 + 32'(b) * 32'h1000);

    // Out-of-range channel clamps to ch0; a full read FIFO blocks requests.
    bus.r_fifo_cnt = 12'd800;
    r_fs_pulse(3'd5);
    rd_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ui_clk);
      if (bus.pkg_rd_areq) rd_seen++;
    end
    chk("rd blocked at cnt 800", 64'(rd_seen), 64'(0));
    bus.r_fifo_cnt = 12'd0;
    for (int b = 0; b < 4; b++)
      rd_burst($sformatf("rdClamp b%0d", b), 32'h0040_0000 + 32'(b) * 32'h1000);

    wr_frame0("frmC", 32'h0080_0000);
    wr_frame0("frmD", 32'h0000_0000);

    // Reset while a write burst is outstanding.
    fs0_pulse();
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge ui_clk);
      if (bus.pkg_wr_areq) got = 1'b1;
    end
    chk("frmE areq seen", 64'(got), 64'(1));
    chk("frmE addr", 64'(bus.pkg_wr_addr), 64'(32'h0040_0000));
    repeat (5) @(negedge ui_clk);
    ui_rstn = 1'b0;
    #1;
    chk("midrst w_fifo_rst", 64'(bus.w_fifo_rst), 64'(2'b11));
    chk("midrst r_fifo_rst", 64'(bus.r_fifo_rst), 64'(1));
    chk("midrst wr_addr", 64'(bus.pkg_wr_addr), 64'(0));
    chk("midrst rd_addr", 64'(bus.pkg_rd_addr), 64'(0));
    chk("midrst wr_ch", 64'(bus.pkg_wr_ch), 64'(0));
    chk("midrst wr_areq", 64'(bus.pkg_wr_areq), 64'(0));
    repeat (2) @(negedge ui_clk);
    ui_rstn = 1'b1;
    @(negedge ui_clk);
    bus.pkg_wr_last = 1'b1;
    @(negedge ui_clk);
    bus.pkg_wr_last = 1'b0;

    // Both channels eligible: alternating grants; ch1 restarted mid-frame.
    bus.w_fifo_cnt = {12'd256, 12'd256};
    @(negedge ui_clk);
    bus.w_fs = 2'b11;
    @(negedge ui_clk);
    bus.w_fs = 2'b00;
    wr_burst("rr ch0 b0", 32'h0000_0000, 3'd0, 2'b00, 2'b00);
    wr_burst("rr ch1 b0", 32'h0100_0000, 3'd1, 2'b00, 2'b00);
    wr_burst("rr ch0 b1", 32'h0000_1000, 3'd0, 2'b00, 2'b00);
    wr_burst("rr ch1 b1", 32'h0100_1000, 3'd1, 2'b00, 2'b00);
    wr_burst("rr ch0 b2", 32'h0000_2000, 3'd0, 2'b00, 2'b00);
    wr_burst("abort ch1 b2", 32'h0100_2000, 3'd1, 2'b10, 2'b00);
    chk("abort ch1 set", 64'(bus.w_abort), 64'(2'b10));
    wr_burst("rr ch0 b3", 32'h0000_3000, 3'd0, 2'b00, 2'b01);
    wr_burst("ch1 restart b0", 32'h0100_0000, 3'd1, 2'b00, 2'b00);
    chk("abort sticky", 64'(bus.w_abort), 64'(2'b10));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fdma_mc_frame_ctrl.md
Name: fdma_mc_frame_ctrl

Overview:
Multi-channel successor to the single-channel FDMA frame controller. It schedules WCH video write streams and one selectable read stream onto a single FDMA packet port pair, with per-channel multi-buffer rotation. The read side always fetches the most recently completed buffer of the selected channel, which prevents tearing. The block runs entirely in ui_clk: FIFOs, frame-start synchronisers and clock crossing live outside it.

Parameters:
WCH, 2, number of write channels (1..8)
BUF_NUM, 3, frame buffers per channel (2..8)
PKG_SIZE, 256, beats per FDMA burst
BEAT_BYTES, 16, bytes per 128-bit beat
FRAME_BYTES, 1228800, bytes per frame; must be a multiple of PKG_SIZE*BEAT_BYTES (elaboration error otherwise)
BASE_ADDR, 0, byte base address
CH_STRIDE, 32'h0100_0000, byte distance between channel regions
BUF_STRIDE, 32'h0040_0000, byte distance between buffers
RFIFO_DEPTH, 1024, read FIFO depth in beats
RST_CYC, 10, FIFO reset assert cycles; settle time equals RST_CYC again

Ports:
ui_clk  in  1  sole clock
ui_rstn  in  1  asynchronous, active-low reset
w_fs  in  WCH  per-channel frame-start pulse (1 cycle, already in ui_clk)
w_fifo_cnt  in  WCH*12  per-channel write-FIFO read_data_count
w_fifo_rst  out  WCH  per-channel write-FIFO reset
r_fs  in  1  read frame-start pulse
r_ch_sel  in  3  channel to display, sampled on r_fs
r_fifo_cnt  in  12  read-FIFO wr_data_count
r_fifo_rst  out  1  read-FIFO reset
pkg_wr_areq  out  1  write burst request pulse
pkg_wr_last  in  1  last beat of write burst
pkg_wr_addr  out  32  write burst byte address
pkg_wr_size  out  32  constant PKG_SIZE
pkg_wr_ch  out  3  channel owning the current write burst (FIFO rd_en mux select)
pkg_rd_areq  out  1  read burst request pulse
pkg_rd_last  in  1  last beat of read burst
pkg_rd_addr  out  32  read burst byte address
pkg_rd_size  out  32  constant PKG_SIZE
w_frame_done  out  WCH  1-cycle pulse per completed channel frame
w_abort  out  WCH  sticky: a frame was restarted before completion; cleared only by reset

Behaviour:
- Reset values: w_fifo_rst and r_fifo_rst all 1. All areq, frame_done and abort outputs 0. Addresses 0. pkg_wr_ch 0. All buffer indices 0. done_valid 0.
- Derived constants: BURST_BYTES = PKG_SIZE*BEAT_BYTES; BURSTS = FRAME_BYTES/BURST_BYTES.
- Per-channel FSM states: IDLE -> (w_fs) RST -> ARM -> IDLE.
  - RST: w_fifo_rst held 1 for RST_CYC cycles, then 0 for RST_CYC settle cycles, then move to ARM with bcnt=0.
  - ARM: channel is eligible when w_fifo_cnt[ch] >= PKG_SIZE.
- Shared write engine states: W_IDLE, W_REQ, W_WAIT.
  - W_IDLE: round-robin grant among eligible channels, starting after the last granted channel. Register pkg_wr_ch and pkg_wr_addr = BASE_ADDR + ch*CH_STRIDE + wbuf[ch]*BUF_STRIDE + bcnt[ch]*BURST_BYTES.
  - W_REQ: pkg_wr_areq=1 for exactly one cycle.
  - W_WAIT: wait for pkg_wr_last. Address and channel stay stable from areq through last.
  - On last: bcnt[ch]++. If bcnt reaches BURSTS: done_buf[ch]=wbuf[ch], done_valid[ch]=1, wbuf[ch] advances modulo BUF_NUM (BUF_NUM-1 -> 0), w_frame_done[ch] pulses, channel returns to IDLE.
  - Next areq comes no earlier than 2 cycles after last.
- w_fs on a channel that is not in IDLE:
  - Set w_abort[ch].
  - If that channel owns the burst in flight, the burst completes normally.
  - The channel then re-enters RST with bcnt=0. wbuf is not advanced and done_buf is unchanged.
- Read FSM states: IDLE -> (r_fs) RST -> DATA_REQ/DATA_WAIT -> IDLE.
  - On r_fs: latch rch = r_ch_sel. Values >= WCH are clamped to 0.
  - On r_fs: latch rbuf = done_buf[rch] if done_valid[rch], else 0.
  - RST timing is identical to the write side, using r_fifo_rst.
  - A burst is issued when r_fifo_cnt <= RFIFO_DEPTH - PKG_SIZE. Address = BASE_ADDR + rch*CH_STRIDE + rbuf*BUF_STRIDE + rbcnt*BURST_BYTES.
  - pkg_rd_areq is a 1-cycle pulse. After BURSTS bursts, return to IDLE.
  - r_fs mid-frame: finish the burst in flight, then restart with a fresh latch.
- Simultaneous events:
  - Read and write engines are independent and may overlap.
  - w_frame_done and r_fs in the same cycle: the read latches the new done_buf (write update wins).
  - Simultaneous w_fs on several channels is handled independently per channel.
- Reset mid-burst: everything returns to reset values immediately. Any pending last is ignored.

Test Plan:
(Params WCH=2, BUF_NUM=3, PKG_SIZE=256, BEAT_BYTES=16, FRAME_BYTES=16384, BASE_ADDR=0, RST_CYC=10; each frame is 4 bursts of 4096 B.)
- Reset release, w_fs[0], cnt0=256 held, last returned 20 cycles after each areq -> w_fifo_rst[0] high 10 cycles, low 10 cycles; areq addresses 0x0, 0x1000, 0x2000, 0x3000; w_frame_done[0] pulse; next frame starts at 0x0040_0000.
- Both channels eligible continuously -> grants alternate ch0, ch1, ch0, ch1; ch1 first address 0x0100_0000; pkg_wr_ch matches each grant.
- Three complete ch0 frames -> buffer bases 0x0, 0x0040_0000, 0x0080_0000; fourth frame wraps to 0x0.
- ch0 completes buffer 1, then r_fs with r_ch_sel=0 and r_fifo_cnt=0 -> read addresses 0x0040_0000..0x0040_3000; with r_fifo_cnt=800, no pkg_rd_areq is issued.
- w_fs[1] during ch1 burst 2 -> that burst finishes; w_abort[1]=1; ch1 restarts at buffer base with bcnt 0; no frame_done pulse.
- ui_rstn low while W_WAIT -> outputs return to reset values immediately; a later pkg_wr_last produces no bcnt change.
